// File: rtl/multadd_pkg.sv
// Shared widths, state encodings and Q15 rounding helper for the multiply-add output path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package multadd_pkg;

   // Default widths for the DSP48 product path feeding the Q15 sample stream.
   localparam int P_W_DEF   = 48;
   localparam int ACC_W_DEF = 56;
   localparam int SHIFT_DEF = 15;
   localparam int OUT_W_DEF = 16;

   // Signed saturation bounds of the default output word.
   localparam logic signed [ACC_W_DEF-1:0] SAT_HI_DEF = (ACC_W_DEF'(1) <<< (OUT_W_DEF-1)) - 1;
   localparam logic signed [ACC_W_DEF-1:0] SAT_LO_DEF = -(ACC_W_DEF'(1) <<< (OUT_W_DEF-1));

   // Frame side: IDLE means no product is held in the open frame.
   typedef enum logic {
      F_IDLE,
      F_ACCUM
   } frame_state_t;

   // Output side: FULL is exactly out_valid.
   typedef enum logic {
      O_EMPTY,
      O_FULL
   } out_state_t;

   // Round half-up, shift and clip an accumulator value at the default widths.
   // Returns {clipped, data}.
   function automatic logic [OUT_W_DEF:0] sat_round(input logic signed [ACC_W_DEF-1:0] v);
      logic signed [ACC_W_DEF-1:0] r;
      logic [OUT_W_DEF:0]          res;
      r   = (v + (ACC_W_DEF'(1) <<< (SHIFT_DEF-1))) >>> SHIFT_DEF;
      res = {1'b0, r[OUT_W_DEF-1:0]};
      if (r > SAT_HI_DEF) begin
         res = {1'b1, SAT_HI_DEF[OUT_W_DEF-1:0]};
      end else if (r < SAT_LO_DEF) begin
         res = {1'b1, SAT_LO_DEF[OUT_W_DEF-1:0]};
      end
      return res;
   endfunction

endpackage

// File: rtl/round_sat.sv
// Round half-up (ties toward +inf), arithmetic right shift, clip to OUT_W signed.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; caller registers the result.
module round_sat
   import multadd_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int SHIFT = SHIFT_DEF,
   parameter int OUT_W = OUT_W_DEF
)(
   input  logic signed [ACC_W-1:0] din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    sat
);

   localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) <<< (SHIFT-1);
   localparam logic signed [ACC_W-1:0] MAX_V = (ACC_W'(1) <<< (OUT_W-1)) - 1;
   localparam logic signed [ACC_W-1:0] MIN_V = -(ACC_W'(1) <<< (OUT_W-1));

   logic signed [ACC_W-1:0] biased;
   logic signed [ACC_W-1:0] shifted;

   // Bias by half an output LSB, shift down, then clip to the signed output range.
   always_comb begin
      biased  = din + HALF;
      shifted = biased >>> SHIFT;
      dout    = shifted[OUT_W-1:0];
      sat     = 1'b0;
      if (shifted > MAX_V) begin
         dout = MAX_V[OUT_W-1:0];
         sat  = 1'b1;
      end else if (shifted < MIN_V) begin
         dout = MIN_V[OUT_W-1:0];
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/multadd_accum_quant.sv
// Accumulate N_ACC signed products, then round/shift/saturate to a Q15 sample.
// Latency: result valid 2 edges after the closing sample (close reg, then output reg).
// Backpressure: none upstream; an unread result is overwritten and flagged in sticky overrun.
module multadd_accum_quant
   import multadd_pkg::*;
#(
   parameter int P_W   = P_W_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int N_ACC = 8,
   parameter int SHIFT = SHIFT_DEF,
   parameter int OUT_W = OUT_W_DEF
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sclr,
   input  logic                          ce,
   input  logic                          in_valid,
   input  logic signed [P_W-1:0]         p_in,
   input  logic                          flush,
   input  logic                          out_ready,
   output logic                          out_valid,
   output logic signed [OUT_W-1:0]       out_data,
   output logic                          out_sat,
   output logic                          overrun,
   output logic [$clog2(N_ACC+1)-1:0]    frame_cnt
);

   localparam int               CNT_W = $clog2(N_ACC+1);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_ACC-1);

   frame_state_t            frame_st;
   frame_state_t            frame_nxt;
   out_state_t              out_st;
   out_state_t              out_nxt;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_nxt;
   logic signed [ACC_W-1:0] p_ext;
   logic signed [ACC_W-1:0] final_sum;
   logic signed [ACC_W-1:0] close_dat;
   logic [CNT_W-1:0]        cnt_nxt;
   logic                    accept;
   logic                    close;
   logic                    close_vld;
   logic                    ovr_set;
   logic signed [OUT_W-1:0] rs_data;
   logic                    rs_sat;

   // ce gates both acceptance and flush; with ce low the frame is frozen.
   assign accept = ce & in_valid;
   assign p_ext  = ACC_W'(p_in);

   // Frame next-state: add the accepted product, close on the last slot or on a non-empty flush.
   always_comb begin
      frame_nxt = frame_st;
      acc_nxt   = acc;
      cnt_nxt   = frame_cnt;
      close     = 1'b0;
      final_sum = acc + (accept ? p_ext : '0);
      if (accept && (frame_cnt == LAST)) begin
         close = 1'b1;
      end else if (ce && flush && ((frame_cnt != '0) || in_valid)) begin
         close = 1'b1;
      end
      if (close) begin
         // Clearing at the close edge lets the next frame start the very next cycle.
         acc_nxt   = '0;
         cnt_nxt   = '0;
         frame_nxt = F_IDLE;
      end else if (accept) begin
         acc_nxt   = final_sum;
         cnt_nxt   = frame_cnt + CNT_W'(1);
         frame_nxt = F_ACCUM;
      end
   end

   // Frame state, accumulator and close register; sclr behaves like rst at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_st  <= F_IDLE;
         acc       <= '0;
         frame_cnt <= '0;
         close_vld <= 1'b0;
         close_dat <= '0;
      end else if (sclr) begin
         frame_st  <= F_IDLE;
         acc       <= '0;
         frame_cnt <= '0;
         close_vld <= 1'b0;
         close_dat <= '0;
      end else begin
         frame_st  <= frame_nxt;
         acc       <= acc_nxt;
         frame_cnt <= cnt_nxt;
         close_vld <= close;
         if (close) begin
            close_dat <= final_sum;
         end
      end
   end

   round_sat #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_round_sat (
      .din  (close_dat),
      .dout (rs_data),
      .sat  (rs_sat)
   );

   // Output next-state: a new result always wins over a same-edge transfer.
   always_comb begin
      out_nxt = out_st;
      ovr_set = 1'b0;
      case (out_st)
         O_EMPTY: begin
            if (close_vld) begin
               out_nxt = O_FULL;
            end
         end
         O_FULL: begin
            if (close_vld) begin
               ovr_set = ~out_ready;
            end else if (out_ready) begin
               out_nxt = O_EMPTY;
            end
         end
         default: out_nxt = O_EMPTY;
      endcase
   end

   // Output register; data only changes on a new result, so it holds while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_st   <= O_EMPTY;
         out_data <= '0;
         out_sat  <= 1'b0;
         overrun  <= 1'b0;
      end else if (sclr) begin
         out_st   <= O_EMPTY;
         out_data <= '0;
         out_sat  <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         out_st <= out_nxt;
         if (close_vld) begin
            out_data <= rs_data;
            out_sat  <= rs_sat;
         end
         if (ovr_set) begin
            overrun <= 1'b1;
         end
      end
   end

   assign out_valid = (out_st == O_FULL);

endmodule
